// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with double-buffered digit data committed only at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int          ACTIVE_LOW  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      load_i,
  input  logic                      blank_i,
  output logic                      pending_o,
  output logic                      frame_o,
  output logic [NUM_DIGITS-1:0]     anode_o,
  output logic [6:0]                cathode_o,
  output logic                      dp_o
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic                         tick_last;
  logic                         wrap;

  logic [NUM_DIGITS-1:0][3:0]   act_dig;
  logic [NUM_DIGITS-1:0][3:0]   stg_dig;
  logic [NUM_DIGITS-1:0]        act_dp;
  logic [NUM_DIGITS-1:0]        stg_dp;
  logic                         pending;

  logic [3:0]                   cur_nib;
  logic                         cur_dp;
  logic                         dark;
  logic [NUM_DIGITS-1:0]        sel_hot;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick_last = (cnt == CNT_LAST);
  assign wrap      = tick_last && (idx == IDX_LAST);
  assign pending_o = pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick_last) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Commit uses the pending flag from before this edge, so a load landing on
  // the wrap cycle itself waits for the following frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_dig <= '0;
      act_dp  <= '0;
      stg_dig <= '0;
      stg_dp  <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        act_dig <= stg_dig;
        act_dp  <= stg_dp;
        pending <= 1'b0;
      end
      if (load_i) begin
        stg_dig <= digits_i;
        stg_dp  <= dp_i;
        pending <= 1'b1;
      end
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  lead;

  always_comb begin
    lz_dark = '0;
    lead    = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
      lead       = lead & (act_dig[k] == 4'h0) & ~act_dp[k];
      lz_dark[k] = lead;
    end
  end

  always_comb begin
    cur_nib = act_dig[idx];
    cur_dp  = act_dp[idx];
    dark    = blank_i | lz_dark[idx];
    sel_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end
`else
  always_comb begin
    cur_nib = act_dig[idx];
    cur_dp  = act_dp[idx];
    dark    = blank_i;
    sel_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      anode_o   <= {NUM_DIGITS{INV}};
      cathode_o <= {7{INV}};
      dp_o      <= INV;
      frame_o   <= 1'b0;
    end else begin
      frame_o <= (cnt == '0) && (idx == '0);
      if (dark) begin
        anode_o   <= {NUM_DIGITS{INV}};
        cathode_o <= {7{INV}};
        dp_o      <= INV;
      end else begin
        anode_o   <= sel_hot ^ {NUM_DIGITS{INV}};
        cathode_o <= hex7(cur_nib) ^ {7{INV}};
        dp_o      <= cur_dp ^ INV;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (4 digits, 4-cycle dwell, active-low) against a
// position-arithmetic reference model, plus directed literal checks.
module tb_seg_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;
`ifdef SEG_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i    = '0;
  logic        load_i  = 1'b0;
  logic        blank_i = 1'b0;
  logic        pending_o;
  logic        frame_o;
  logic [3:0]  anode_o;
  logic [6:0]  cathode_o;
  logic        dp_o;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .digits_i  (digits_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .blank_i   (blank_i),
    .pending_o (pending_o),
    .frame_o   (frame_o),
    .anode_o   (anode_o),
    .cathode_o (cathode_o),
    .dp_o      (dp_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: output after post-reset edge e shows scan position e-1.
  int          m_e = 0;
  int          m_pos, m_dig, m_hi;
  logic [15:0] m_show, m_stage;
  logic [3:0]  m_show_dp, m_stage_dp;
  logic [3:0]  m_nib;
  bit          m_pend, m_dark;
  bit          chk_en = 1'b0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_cat;
  logic        exp_dp, exp_fr, exp_pend;

  always @(posedge clock) begin
    if (reset) begin
      m_e = 0; m_show = '0; m_show_dp = '0; m_stage = '0; m_stage_dp = '0; m_pend = 1'b0;
      exp_an = 4'hF; exp_cat = 7'h7F; exp_dp = 1'b1; exp_fr = 1'b0; exp_pend = 1'b0;
    end else begin
      m_e++;
      m_pos  = m_e - 1;
      m_dig  = (m_pos / DIV) % N;
      exp_fr = (m_pos % FR) == 0;
      m_nib  = m_show[4*m_dig +: 4];
      m_hi   = 0;
      for (int j = 0; j < N; j++)
        if (m_show[4*j +: 4] != 4'h0 || m_show_dp[j]) m_hi = j;
      m_dark = blank_i || (LZ && m_dig > m_hi);
      if (m_dark) begin
        exp_an = 4'hF; exp_cat = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << m_dig);
        exp_cat = ~seg_tab[m_nib];
        exp_dp  = ~m_show_dp[m_dig];
      end
      if ((m_e % FR) == 0 && m_pend) begin
        m_show = m_stage; m_show_dp = m_stage_dp; m_pend = 1'b0;
      end
      if (load_i) begin
        m_stage = digits_i; m_stage_dp = dp_i; m_pend = 1'b1;
      end
      exp_pend = m_pend;
    end
    chk_en = 1'b1;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("anode",   32'(anode_o),   32'(exp_an));
      chk("cathode", 32'(cathode_o), 32'(exp_cat));
      chk("dp",      32'(dp_o),      32'(exp_dp));
      chk("frame",   32'(frame_o),   32'(exp_fr));
      chk("pending", 32'(pending_o), 32'(exp_pend));
      chk("onehot",  32'($countones(~anode_o) <= 1), 32'(1));
    end
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 2000 && m_e < n; i++) tick;
    chk("run_to_bound", 32'(m_e >= n), 32'(1));
  endtask

  task automatic to_pos(input int p);
    for (int i = 0; i < FR && ((m_e - 1) % FR) != p; i++) tick;
    chk("to_pos_bound", 32'((m_e - 1) % FR), 32'(p));
  endtask

  task automatic sync_load(input logic [15:0] d, input logic [3:0] dp);
    to_pos(2);
    digits_i = d; dp_i = dp; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    to_pos(0);
  endtask

  logic [15:0] tmp;

  initial begin
    repeat (3) tick;
    chk("rst_anode", 32'(anode_o),   32'(4'hF));
    chk("rst_cath",  32'(cathode_o), 32'(7'h7F));
    chk("rst_pend",  32'(pending_o), 32'(0));
    chk("rst_frame", 32'(frame_o),   32'(0));

    reset = 1'b0;
    tick;
    chk("first_anode", 32'(anode_o),   32'(4'b1110));
    chk("first_cath",  32'(cathode_o), 32'(7'h40));
    chk("first_frame", 32'(frame_o),   32'(1));
    repeat (4) tick;
    chk("scan_digit1", 32'(anode_o), LZ ? 32'(4'hF) : 32'(4'b1101));
    chk("frame_low",   32'(frame_o), 32'(0));

    tick;
    digits_i = 16'h12AF; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    chk("load_pend", 32'(pending_o), 32'(1));
    run_to(17);
    chk("load_d0",   32'(cathode_o), 32'(7'h0E));
    chk("load_pclr", 32'(pending_o), 32'(0));
    run_to(29);
    chk("load_d3_an", 32'(anode_o),   32'(4'b0111));
    chk("load_d3",    32'(cathode_o), 32'(7'h79));

    run_to(35);
    digits_i = 16'h1111; load_i = 1'b1; tick; load_i = 1'b0;
    run_to(40);
    digits_i = 16'h2222; load_i = 1'b1; tick; load_i = 1'b0;
    run_to(49);
    chk("last_wins", 32'(cathode_o), 32'(7'h24));

    run_to(63);
    digits_i = 16'h3333; load_i = 1'b1; tick; load_i = 1'b0;
    chk("bnd_pend", 32'(pending_o), 32'(1));
    tick;
    chk("bnd_old", 32'(cathode_o), 32'(7'h24));
    run_to(81);
    chk("bnd_new",  32'(cathode_o), 32'(7'h30));
    chk("bnd_pclr", 32'(pending_o), 32'(0));

    blank_i = 1'b1;
    tick;
    chk("blank_an", 32'(anode_o), 32'(4'hF));
    chk("blank_dp", 32'(dp_o),    32'(1));
    repeat (9) tick;
    blank_i = 1'b0;

`ifdef SEG_LZ_SUPPRESS_EN
    sync_load(16'h0050, 4'b0000);
    chk("lz_d0", 32'(cathode_o), 32'(7'h40));
    to_pos(4);
    chk("lz_d1", 32'(cathode_o), 32'(7'h12));
    to_pos(8);
    chk("lz_d2", 32'(anode_o), 32'(4'hF));
    to_pos(12);
    chk("lz_d3", 32'(anode_o), 32'(4'hF));
    sync_load(16'h0000, 4'b0000);
    chk("lz0_d0", 32'(anode_o), 32'(4'b1110));
    to_pos(4);
    chk("lz0_d1", 32'(anode_o), 32'(4'hF));
    sync_load(16'h0000, 4'b1000);
    to_pos(12);
    chk("lzdp_an",  32'(anode_o),   32'(4'b0111));
    chk("lzdp_cat", 32'(cathode_o), 32'(7'h40));
    chk("lzdp_dp",  32'(dp_o),      32'(0));
`endif

    digits_i = 16'h4567; load_i = 1'b1; tick; load_i = 1'b0;
    chk("rp_pend", 32'(pending_o), 32'(1));
    reset = 1'b1;
    repeat (2) tick;
    chk("rp_pclr", 32'(pending_o), 32'(0));
    reset = 1'b0;
    tick;
    chk("rp_an",  32'(anode_o),   32'(4'b1110));
    chk("rp_cat", 32'(cathode_o), 32'(7'h40));
    run_to(FR + 1);
    chk("rp_zero", 32'(cathode_o), 32'(7'h40));

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++)
        tmp[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      digits_i = tmp;
      dp_i     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      load_i   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blank_i = ~blank_i;
      reset    = ($urandom_range(0, 499) == 0);
      tick;
    end
    reset = 1'b0; load_i = 1'b0; blank_i = 1'b0;
    repeat (2 * FR) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
